// File: rtl/gate_pipe_if.sv
// gate_pipe_if -- request/result handshake bundle for gate_pipe.
//   Request : in_valid, in_ready, a, b, op, use_acc
//   Result  : out_valid, out_ready, y, zero, par
//   master  : the side that issues requests and consumes results
//   slave   : gate_pipe itself
interface gate_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             use_acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             par;

    modport master (
        output in_valid, a, b, op, use_acc, out_ready,
        input  in_ready, out_valid, y, zero, par
    );

    modport slave (
        input  in_valid, a, b, op, use_acc, out_ready,
        output in_ready, out_valid, y, zero, par
    );
endinterface

// File: rtl/gate_pipe.sv
// gate_pipe -- two-stage valid/ready pipeline applying a bitwise logic op.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : gate_pipe_if.slave (request a/b/op/use_acc, result y/zero/par)
// S1 registers the request; the op is evaluated on the S1->S2 move and S2
// holds y plus its zero/parity flags. An internal accumulator captures every
// result that moves into S2 and can replace operand B of later requests.
module gate_pipe #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    gate_pipe_if.slave    bus
);
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s1_use_acc_q, s1_use_acc_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             s2_adv;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] res;

    assign s2_adv   = !s2_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = bus.in_valid && in_ready;

    // acc always holds the result of the request just ahead of S1, so a
    // use_acc request directly behind another sees its result without a bubble.
    assign b_eff = s1_use_acc_q ? acc_q : s1_b_q;

    always_comb begin
        res = '0;
        case (s1_op_q)
            OP_AND:  res = s1_a_q & b_eff;
            OP_OR:   res = s1_a_q | b_eff;
            OP_XOR:  res = s1_a_q ^ b_eff;
            OP_NAND: res = ~(s1_a_q & b_eff);
            OP_NOR:  res = ~(s1_a_q | b_eff);
            OP_XNOR: res = ~(s1_a_q ^ b_eff);
            OP_ANDN: res = s1_a_q & ~b_eff;
            default: res = s1_a_q;
        endcase
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_op_d      = s1_op_q;
        s1_use_acc_d = s1_use_acc_q;
        s2_valid_d   = s2_valid_q;
        y_d          = y_q;
        zero_d       = zero_q;
        par_d        = par_q;
        acc_d        = acc_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            // y/flags only change when a real result arrives; they are
            // meaningless while out_valid is low anyway.
            if (s1_valid_q) begin
                y_d    = res;
                zero_d = (res == '0);
                par_d  = ^res;
                acc_d  = res;
            end
        end

        // accept implies S1 is empty or moving into S2 this cycle.
        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_a_d       = bus.a;
            s1_b_d       = bus.b;
            s1_op_d      = bus.op;
            s1_use_acc_d = bus.use_acc;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= '0;
            s1_use_acc_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            y_q          <= '0;
            zero_q       <= 1'b0;
            par_q        <= 1'b0;
            acc_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s1_use_acc_q <= s1_use_acc_d;
            s2_valid_q   <= s2_valid_d;
            y_q          <= y_d;
            zero_q       <= zero_d;
            par_q        <= par_d;
            acc_q        <= acc_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.par       = par_q;
endmodule

// File: tb/tb_gate_pipe.sv
module tb_gate_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    gate_pipe_if #(.WIDTH(4)) bus ();

    gate_pipe #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] fop(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'b000: fop = a & b;
            3'b001: fop = a | b;
            3'b010: fop = a ^ b;
            3'b011: fop = ~(a & b);
            3'b100: fop = ~(a | b);
            3'b101: fop = ~(a ^ b);
            3'b110: fop = a & ~b;
            default: fop = a;
        endcase
    endfunction

    // Reference model sampled at negedge: queue of expected results in
    // acceptance order plus a model accumulator.
    logic [3:0] expq[$];
    logic [3:0] macc = '0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_y = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            expq.delete();
            macc = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("stall_y", {28'd0, bus.y}, {28'd0, prev_y});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    chk("extra_out", 32'd1, 32'd0);
                end else begin
                    logic [3:0] e;
                    e = expq.pop_front();
                    chk("mon_y", {28'd0, bus.y}, {28'd0, e});
                    chk("mon_zero", {31'd0, bus.zero}, {31'd0, (e == 4'd0)});
                    chk("mon_par", {31'd0, bus.par}, {31'd0, ^e});
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                logic [3:0] r;
                r = fop(bus.op, bus.a, bus.use_acc ? macc : bus.b);
                macc = r;
                expq.push_back(r);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_y = bus.y;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.use_acc = ua;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       use_acc;
        logic [3:0] y;
        logic       zero;
        logic       par;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;
        bus.use_acc = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{3'b000, 4'b1100, 4'b1010, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[1] = '{3'b001, 4'b1100, 4'b1010, 1'b0, 4'b1110, 1'b0, 1'b1};
        vecs[2] = '{3'b010, 4'b1100, 4'b1010, 1'b0, 4'b0110, 1'b0, 1'b0};
        vecs[3] = '{3'b011, 4'b1100, 4'b1010, 1'b0, 4'b0111, 1'b0, 1'b1};
        vecs[4] = '{3'b100, 4'b1100, 4'b1010, 1'b0, 4'b0001, 1'b0, 1'b1};
        vecs[5] = '{3'b101, 4'b1100, 4'b1010, 1'b0, 4'b1001, 1'b0, 1'b0};
        vecs[6] = '{3'b110, 4'b1100, 4'b1010, 1'b0, 4'b0100, 1'b0, 1'b1};
        vecs[7] = '{3'b111, 4'b1100, 4'b1010, 1'b0, 4'b1100, 1'b0, 1'b0};
        vecs[8] = '{3'b000, 4'b0101, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[9] = '{3'b101, 4'b0110, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b0};

        // Reset state
        do_reset();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_y", {28'd0, bus.y}, 32'd0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd0);
        chk("rst_par", {31'd0, bus.par}, 32'd0);

        // Op table, back-to-back, no backpressure: result 2 cycles after issue
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i >= 2) begin
                chk("tbl_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("tbl_y", {28'd0, bus.y}, {28'd0, vecs[i-2].y});
                chk("tbl_zero", {31'd0, bus.zero}, {31'd0, vecs[i-2].zero});
                chk("tbl_par", {31'd0, bus.par}, {31'd0, vecs[i-2].par});
            end else begin
                chk("tbl_lat", {31'd0, bus.out_valid}, 32'd0);
            end
            if (i < 10) req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_acc);
            else bus.in_valid = 1'b0;
            step();
        end
        chk("tbl_drained", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back accumulator use right after reset
        do_reset();
        req(3'b010, 4'b0101, 4'b1111, 1'b1);
        step();
        req(3'b010, 4'b0101, 4'b1111, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("acc1_y", {28'd0, bus.y}, 32'h5);
        chk("acc1_zero", {31'd0, bus.zero}, 32'd0);
        chk("acc1_par", {31'd0, bus.par}, 32'd0);
        step();
        chk("acc2_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("acc2_y", {28'd0, bus.y}, 32'h0);
        chk("acc2_zero", {31'd0, bus.zero}, 32'd1);
        step();

        // Fill under backpressure, then drain
        do_reset();
        bus.out_ready = 1'b0;
        req(3'b000, 4'b1111, 4'b0011, 1'b0);
        #1 chk("fill_rdy0", {31'd0, bus.in_ready}, 32'd1);
        step();
        req(3'b001, 4'b1000, 4'b0001, 1'b0);
        #1 chk("fill_rdy1", {31'd0, bus.in_ready}, 32'd1);
        step();
        req(3'b111, 4'b0110, 4'b0000, 1'b0);
        #1 chk("fill_rdy2", {31'd0, bus.in_ready}, 32'd0);
        chk("fill_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("fill_y0", {28'd0, bus.y}, 32'h3);
        step();
        chk("fill_hold_rdy", {31'd0, bus.in_ready}, 32'd0);
        chk("fill_hold_y", {28'd0, bus.y}, 32'h3);
        bus.out_ready = 1'b1;
        #1 chk("fill_rel_rdy", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("fill_y1", {28'd0, bus.y}, 32'h9);
        step();
        chk("fill_y2", {28'd0, bus.y}, 32'h6);
        step();
        chk("fill_empty", {31'd0, bus.out_valid}, 32'd0);
        chk("fill_q", expq.size(), 32'd0);

        // out_ready toggling with continuous requests, mixing use_acc
        begin
            int n;
            logic took;
            n = 0;
            bus.out_ready = 1'b0;
            req(3'b010, 4'd1, 4'd14, 1'b0);
            for (int c = 0; c < 40 && n < 12; c++) begin
                #1 took = bus.in_ready;
                step();
                bus.out_ready = ~bus.out_ready;
                if (took) begin
                    n++;
                    if (n < 12) req(3'(n % 8), 4'(n * 3 + 1), 4'(~n), (n % 3) == 0);
                    else bus.in_valid = 1'b0;
                end
            end
            chk("tog_sent", n, 32'd12);
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            for (int c = 0; c < 10 && expq.size() != 0; c++) step();
            step();
            chk("tog_q", expq.size(), 32'd0);
        end

        // Reset with both stages full discards everything, acc cleared
        bus.out_ready = 1'b0;
        req(3'b111, 4'b1010, 4'b0000, 1'b0);
        step();
        req(3'b111, 4'b0111, 4'b0000, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("mid_full", {31'd0, bus.out_valid}, 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        req(3'b010, 4'b0011, 4'b1111, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("mid_no_pulse", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk("mid_acc_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("mid_acc_y", {28'd0, bus.y}, 32'h3);
        step();
        chk("mid_end", {31'd0, bus.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/gate_pipe.md
GATE_PIPE -- requirements
Module: gate_pipe

Interface
REQ-001 Parameter WIDTH, default 4: operand and result bit width; SHALL support any WIDTH >= 1.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 reset_n  input  1  reset is synchronous and active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  3  operation select (see REQ-012).
REQ-009 use_acc  input  1  1: replace operand B with accumulator value.
REQ-010 out_valid / out_ready  output / input  1 each  result handshake.
REQ-011 y  output  WIDTH  result; zero  output  1  (y == 0); par  output  1  XOR-reduction of y.

Function
REQ-012 op encoding SHALL be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 A & ~B, 111 pass A; all operations bitwise over WIDTH bits, no carries.
REQ-013 Two-stage pipeline: S1 registers {a, b, op, use_acc}; S2 registers {y, zero, par}; each stage has its own valid bit.
REQ-014 Request accepted when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-015 s2_adv = !s2_valid || out_ready; in_ready SHALL equal !s1_valid || s2_adv (combinational, no dependency on in_valid).
REQ-016 On s2_adv: S2 loads the S1 result and s2_valid <= s1_valid; S1 loads the new request if accepted, else s1_valid <= 0 (after S1 has moved into S2).
REQ-017 When !s2_adv: S1 and S2 SHALL hold contents; y/zero/par SHALL remain stable while out_valid && !out_ready.
REQ-018 Latency: an accepted request SHALL produce out_valid exactly 2 cycles later when there is no backpressure; throughput 1 result/cycle.
REQ-019 Result computed in the S1->S2 transfer; effective B = use_acc ? acc : b (the S1-registered values).
REQ-020 Accumulator acc (WIDTH bits, internal) SHALL load the computed result on every S1->S2 transfer with s1_valid=1, regardless of use_acc.
REQ-021 Back-to-back use_acc requests SHALL each see the result of the immediately preceding request (no hazard bubble).
REQ-022 zero and par SHALL be computed from the same result written to y, in the same register stage.
REQ-023 Simultaneous accept and drain in the same cycle with both stages full SHALL lose no data and duplicate no data.
REQ-024 Results SHALL leave in acceptance order; no reordering, no drops.

Reset
REQ-025 While reset_n=0 at a rising edge: s1_valid, s2_valid, acc, y, zero, par SHALL clear; zero resets to 0 (flags invalid while out_valid=0).
REQ-026 First edge with reset_n=1: in_ready=1, out_valid=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight requests; no out_valid pulse from pre-reset requests.

Verification (WIDTH=4)
REQ-028 a=1100, b=1010, out_ready=1, ops 000..111 on consecutive cycles -> y = 1000, 1110, 0110, 0111, 0001, 1001, 0100, 1100 on cycles 2..9; par/zero consistent.
REQ-029 After reset, op=010 a=0101 use_acc=1 (acc=0) then op=010 a=0101 use_acc=1 -> y=0101 (zero=0, par=0) then y=0000 (zero=1).
REQ-030 Fill with 3 requests while out_ready=0 -> in_ready drops after second accept; y holds first result; releasing out_ready drains all three in order.
REQ-031 out_ready toggling every cycle with in_valid held 1 -> every accepted request appears exactly once, in order, y stable while stalled.
REQ-032 reset_n=0 for one cycle with both stages valid -> next cycle out_valid=0, in_ready=1, subsequent use_acc op sees acc=0000.
REQ-033 WIDTH=1 and WIDTH=32 elaborations pass REQ-028 pattern (operands replicated/truncated) with identical latency.
